// File: rtl/mips_isa_pkg.sv
// -----------------------------------------------------------------------------
// mips_isa_pkg
// Shared MIPS ISA definitions for the program-side encoder and the control
// decoder. The two blocks must agree on the opcode map, so it lives here once.
//   - OP_* : 6-bit primary opcodes
//   - in_op_e : 3-bit operation class presented to the encoder (6,7 illegal)
//   - field-width constants
//   - op_legal()    : class code is one of the six defined classes
//   - encode_insn() : packs fields into a 32-bit instruction word
// -----------------------------------------------------------------------------
package mips_isa_pkg;

  localparam int OPCODE_W = 6;
  localparam int REG_W    = 5;
  localparam int SHAMT_W  = 5;
  localparam int FUNCT_W  = 6;
  localparam int IMM_W    = 16;
  localparam int TARGET_W = 26;
  localparam int INSN_W   = 32;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_LW    = 3'd1,
    CLS_SW    = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_ADDI  = 3'd4,
    CLS_J     = 3'd5
  } in_op_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= 3'd5);
  endfunction

  // Fields not used by a class are ignored; illegal classes encode as nop.
  function automatic logic [INSN_W-1:0] encode_insn(
    input logic [2:0]          op,
    input logic [REG_W-1:0]    rs,
    input logic [REG_W-1:0]    rt,
    input logic [REG_W-1:0]    rd,
    input logic [FUNCT_W-1:0]  funct,
    input logic [IMM_W-1:0]    imm,
    input logic [TARGET_W-1:0] target
  );
    logic [INSN_W-1:0] w;
    w = 32'h0000_0000;
    case (op)
      CLS_RTYPE: w = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      CLS_LW:    w = {OP_LW,   rs, rt, imm};
      CLS_SW:    w = {OP_SW,   rs, rt, imm};
      CLS_BEQ:   w = {OP_BEQ,  rs, rt, imm};
      CLS_ADDI:  w = {OP_ADDI, rs, rt, imm};
      CLS_J:     w = {OP_J,    target};
      default:   w = 32'h0000_0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// -----------------------------------------------------------------------------
// enc_fifo
// Synchronous FIFO buffering encoded words between the field handshake and
// the instruction-RAM write port. DEPTH must be a power of two and >= 2 so
// the pointers wrap naturally.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, wdata_i : write a word (ignored when full)
//   pop_i           : drop the head word (ignored when empty)
//   rdata_o         : head word
//   full_o, empty_o : status from the registered occupancy
//   count_o         : registered occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign rdata_o   = mem_q[rd_ptr_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   count_q <= count_q - {{(CW-1){1'b0}}, 1'b1};
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mips_inst_encoder.sv
// -----------------------------------------------------------------------------
// mips_inst_encoder
// Accepts instruction fields over a valid/ready handshake, packs them into
// 32-bit MIPS words and writes them to consecutive instruction-RAM addresses
// starting at base_addr. A small FIFO absorbs RAM back-pressure.
// Optional feature macro: MIPS_ENC_CHECK_EN
//   defined   : illegal in_op (6,7) is accepted, dropped, and sets sticky err
//   undefined : illegal in_op is written as 32'h00000000, err tied low
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, base_addr      : begin a program at base_addr (IDLE only)
//   finish                : end of program, drain then pulse done (LOAD only)
//   in_valid/in_ready     : field handshake; in_op/in_rs/in_rt/in_rd/
//                           in_funct/in_imm/in_target are the fields
//   mem_we/mem_addr/mem_wdata/mem_ready : instruction-RAM write port
//   done                  : one-cycle pulse after the last word is written
//   word_count            : words written since start
//   wrapped               : sticky, mem_addr rolled over all-ones
//   err                   : sticky, illegal in_op seen
// -----------------------------------------------------------------------------
module mips_inst_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic                finish,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_op,
  input  logic [4:0]          in_rs,
  input  logic [4:0]          in_rt,
  input  logic [4:0]          in_rd,
  input  logic [5:0]          in_funct,
  input  logic [15:0]         in_imm,
  input  logic [25:0]         in_target,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic                mem_ready,
  output logic                done,
  output logic [ADDR_W:0]     word_count,
  output logic                wrapped,
  output logic                err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              wrapped_q, wrapped_d;

  logic              start_ok_s;
  logic              hs_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [31:0]       head_s;
  logic [31:0]       enc_word_s;
  logic [CNT_W-1:0]  fifo_count_s;

  assign start_ok_s = (state_q == S_IDLE) & start;
  // Ready comes from the registered occupancy, so a pop into a full FIFO
  // frees the slot only on the following cycle.
  assign in_ready   = (state_q == S_LOAD) & ~full_s;
  assign hs_s       = in_valid & in_ready;
  assign enc_word_s = encode_insn(in_op, in_rs, in_rt, in_rd, in_funct, in_imm, in_target);

  assign mem_we     = (fifo_count_s != {CNT_W{1'b0}});
  assign mem_wdata  = empty_s ? 32'h0000_0000 : head_s;
  assign pop_s      = mem_we & mem_ready;
  assign mem_addr   = addr_q;
  assign word_count = wcnt_q;
  assign wrapped    = wrapped_q;
  assign done       = (state_q == S_DONE);

`ifdef MIPS_ENC_CHECK_EN
  logic err_q, err_d;

  assign push_s = hs_s & op_legal(in_op);
  assign err    = err_q;

  // Sticky illegal-class flag, cleared when a new program starts.
  always_comb begin
    err_d = err_q;
    if (start_ok_s) begin
      err_d = 1'b0;
    end else if (hs_s & ~op_legal(in_op)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
`else
  assign push_s = hs_s;
  assign err    = 1'b0;
`endif

  enc_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .wdata_i (enc_word_s),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (fifo_count_s)
  );

  // Program sequencing: finish is honoured only in LOAD, start only in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LOAD;
        else       state_d = S_IDLE;
      end
      S_LOAD: begin
        if (finish) state_d = S_DRAIN;
        else        state_d = S_LOAD;
      end
      S_DRAIN: begin
        if (empty_s) state_d = S_DONE;
        else         state_d = S_DRAIN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Write address, word counter and wrap flag.
  always_comb begin
    addr_d    = addr_q;
    wcnt_d    = wcnt_q;
    wrapped_d = wrapped_q;
    if (start_ok_s) begin
      addr_d    = base_addr;
      wcnt_d    = {(ADDR_W+1){1'b0}};
      wrapped_d = 1'b0;
    end else if (pop_s) begin
      addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      wcnt_d = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};
      if (&addr_q) wrapped_d = 1'b1;
      else         wrapped_d = wrapped_q;
    end else begin
      addr_d    = addr_q;
      wcnt_d    = wcnt_q;
      wrapped_d = wrapped_q;
    end
  end

  // Control and write-port state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= {ADDR_W{1'b0}};
      wcnt_q    <= {(ADDR_W+1){1'b0}};
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
      wrapped_q <= wrapped_d;
    end
  end

endmodule

// File: doc/mips_inst_encoder.md
# mips_inst_encoder

Program-side encoder for the single-cycle MIPS datapath: accepts instruction fields (operation class, registers, immediate/target) over a valid/ready handshake, packs them into 32-bit MIPS words using the same opcode map the control decoder consumes, and writes them sequentially into instruction memory. It sits between the bench/boot loader and the instruction RAM write port. A small FIFO decouples field input from memory back-pressure.

## Interface
- ADDR_W, 8, instruction-memory word-address width
- FIFO_DEPTH, 4, encoded-word buffer depth (power of two, ≥2)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse: load base_addr, begin a program
- base_addr  in  ADDR_W  first word address of the program
- finish  in  1  pulse: no more instructions; drain and complete
- in_valid  in  1  instruction fields valid
- in_ready  out  1  encoder accepts fields this cycle
- in_op  in  3  0=RTYPE 1=LW 2=SW 3=BEQ 4=ADDI 5=J, 6–7 illegal
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_funct  in  6  R-type function code
- in_imm  in  16  I-type immediate/offset
- in_target  in  26  J-type word target
- mem_we  out  1  write request to instruction RAM
- mem_addr  out  ADDR_W  write word address
- mem_wdata  out  32  encoded instruction
- mem_ready  in  1  RAM accepts write this cycle
- done  out  1  one-cycle pulse: program fully written
- word_count  out  ADDR_W+1  words written since start
- wrapped  out  1  sticky: mem_addr wrapped past all-ones
- err  out  1  sticky: illegal in_op seen (see Configuration)

## Operation
- Encoding: RTYPE {6'b000000,rs,rt,rd,5'b0,funct}; LW {6'b100011,rs,rt,imm}; SW {6'b101011,rs,rt,imm}; BEQ {6'b000100,rs,rt,imm}; ADDI {6'b001000,rs,rt,imm}; J {6'b000010,target}. Unused fields ignored.
- FSM: IDLE → (start) LOAD → (finish) DRAIN → (FIFO empty) DONE → IDLE.
- IDLE: in_ready=0; start loads mem_addr←base_addr, clears word_count, wrapped, err.
- LOAD: in_ready = FIFO not full; handshake (in_valid&in_ready) pushes encoded word.
- DRAIN: in_ready=0; FIFO keeps emptying.
- DONE: done=1 for exactly one cycle.
- Write port: mem_we = FIFO not empty; mem_wdata = FIFO head; on mem_we&mem_ready pop, mem_addr+1 (mod 2^ADDR_W), word_count+1. mem_addr all-ones→0 sets wrapped; writing continues.
- start outside IDLE ignored; finish outside LOAD ignored.
- Handshake and finish same cycle: word accepted, then DRAIN.
- Push and pop same cycle with FIFO full: pop frees slot only next cycle (in_ready from registered count).

## Timing
- Reset: state IDLE, FIFO empty, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, word_count=0, wrapped=0, err=0.
- Latency: handshake at edge N with FIFO empty → mem_we=1 with that word in cycle after N.
- Throughput: one word/cycle when mem_ready held high.
- finish with FIFO empty → DONE next cycle, done pulse cycle after that.
- Reset mid-program: FIFO contents discarded, no further writes.

## Configuration
- MIPS_ENC_CHECK_EN defined: illegal in_op (6,7) is accepted but not pushed; err set. Without it: illegal in_op encodes 32'h00000000 (nop) and is written; err tied 0.

## Structure
- Package mips_isa_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), in_op enum, field-width constants; shared with the control decoder.
- Sub-module enc_fifo: synchronous FIFO (push/pop/full/empty/count), parameterised width and depth.

## Test plan
- start base 0x10; ADDI rs=0 rt=8 imm=5 → mem_addr 0x10, mem_wdata 32'h20080005.
- RTYPE rs=8 rt=9 rd=10 funct=0x20, LW rs=0 rt=2 imm=4, SW, BEQ, J target=0x0000010 → 32'h0109502A? no: 32'h01095020, 32'h8C020004, BEQ/SW per formula, 32'h08000010, consecutive addresses.
- mem_ready low 6 cycles while pushing 6 words → in_ready falls after 4, no loss, order preserved.
- base 0xFE, write 3 words → addresses 0xFE,0xFF,0x00; wrapped=1; word_count=3.
- finish with 2 words buffered → both written, then single done pulse; reset asserted mid-DRAIN → mem_we=0 immediately.
- in_op=7: with MIPS_ENC_CHECK_EN err=1, nothing written; without, 32'h00000000 written.
